// File: rtl/ball_grid_tracker.sv
// ball_grid_tracker: finds the densest ball-coloured BLOCK x BLOCK cell in a VGA pixel stream
//
// Ports:
//   CLK, RESET_N            pixel clock, asynchronous active-low reset
//   PIX_VALID               sample qualifier; low freezes every stage
//   VGA_H_CNT, VGA_V_CNT    raster counters (active window starts at X_START/Y_START)
//   R_IN, G_IN, B_IN        input pixel colour
//   ENABLE_MARK             paint hit pixels green (overlay build only)
//   R_OUT, G_OUT, B_OUT     video out, two PIX_VALID cycles behind the input
//   BALL_X, BALL_Y          winning cell column / row of the last published frame
//   BALL_COUNT              hit count of the winning cell
//   BALL_FOUND              winning cell exceeded MIN_COUNT
//   BALL_VALID              one-cycle strobe when BALL_* are refreshed
//
// Build option: define OVERLAY_EN to paint the published ball cell red and
// (with ENABLE_MARK) hit pixels green; without it the video is a plain delay.
module ball_grid_tracker #(
    parameter int X_START   = 144,
    parameter int Y_START   = 35,
    parameter int ACT_W     = 640,
    parameter int ACT_H     = 480,
    parameter int BLOCK     = 16,
    parameter int G_MIN     = 64,
    parameter int G_MARGIN  = 32,
    parameter int MIN_COUNT = 128,
    localparam int COLS = ACT_W / BLOCK,
    localparam int ROWS = ACT_H / BLOCK,
    localparam int XW   = $clog2(COLS),
    localparam int YW   = $clog2(ROWS),
    localparam int CW   = 2 * $clog2(BLOCK) + 1
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          PIX_VALID,
    input  logic [12:0]   VGA_H_CNT,
    input  logic [12:0]   VGA_V_CNT,
    input  logic [7:0]    R_IN,
    input  logic [7:0]    G_IN,
    input  logic [7:0]    B_IN,
    input  logic          ENABLE_MARK,
    output logic [7:0]    R_OUT,
    output logic [7:0]    G_OUT,
    output logic [7:0]    B_OUT,
    output logic [XW-1:0] BALL_X,
    output logic [YW-1:0] BALL_Y,
    output logic [CW-1:0] BALL_COUNT,
    output logic          BALL_FOUND,
    output logic          BALL_VALID
);
    localparam int LB = $clog2(BLOCK);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_e;

    logic [12:0] x, y;
    logic act, hit;
    // Subtraction wraps below the window start, so one unsigned compare per axis covers both bounds.
    assign x   = VGA_H_CNT - 13'(X_START);
    assign y   = VGA_V_CNT - 13'(Y_START);
    assign act = (x < 13'(ACT_W)) && (y < 13'(ACT_H));
    assign hit = ({1'b0, G_IN} >= 9'(G_MIN))
              && ({1'b0, G_IN} > {1'b0, R_IN} + 9'(G_MARGIN))
              && ({1'b0, G_IN} > {1'b0, B_IN} + 9'(G_MARGIN));

    logic          s1_act_q, s1_hit_q, s1_xend_q, s1_yend_q, s1_first_q, s1_last_q;
    logic [XW-1:0] s1_col_q;
    logic [YW-1:0] s1_row_q;
    logic [7:0]    s1_r_q, s1_g_q, s1_b_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_act_q   <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_xend_q  <= 1'b0;
            s1_yend_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
        end else if (PIX_VALID) begin
            s1_act_q   <= act;
            s1_hit_q   <= act && hit;
            s1_xend_q  <= &x[LB-1:0];
            s1_yend_q  <= &y[LB-1:0];
            s1_first_q <= act && x == 13'd0 && y == 13'd0;
            s1_last_q  <= act && x == 13'(ACT_W - 1) && y == 13'(ACT_H - 1);
            s1_col_q   <= XW'(x >> LB);
            s1_row_q   <= YW'(y >> LB);
            s1_r_q     <= R_IN;
            s1_g_q     <= G_IN;
            s1_b_q     <= B_IN;
        end
    end

    state_e state_q, state_d;
    logic   clr, acc_en, publish;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A new (0,0) in ACCUM restarts the frame; it takes precedence over the last-pixel exit.
    always_comb begin
        state_d = state_q;
        if (PIX_VALID) begin
            unique case (state_q)
                IDLE:    state_d = s1_first_q ? ACCUM : IDLE;
                ACCUM:   state_d = (s1_last_q && !s1_first_q) ? PUBLISH : ACCUM;
                PUBLISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The (0,0) pixel that opens a frame is itself accumulated after the clear.
    always_comb begin
        clr     = PIX_VALID && s1_first_q && state_q != PUBLISH;
        acc_en  = PIX_VALID && s1_act_q && (state_q == ACCUM || clr);
        publish = PIX_VALID && state_q == PUBLISH;
    end

    logic [CW-1:0] cnt_q [COLS];
    logic [CW-1:0] cnt_base, cnt_inc, rb_cnt_q, rb_cnt_n, fb_cnt_q;
    logic [XW-1:0] rb_col_q, rb_col_n, fb_col_q;
    logic [YW-1:0] fb_row_q;
    logic          close, row_end, row_take, frame_take;

    always_comb begin
        cnt_base   = clr ? '0 : cnt_q[s1_col_q];
        cnt_inc    = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CW'(s1_hit_q);
        close      = acc_en && s1_xend_q && s1_yend_q;
        row_end    = close && s1_col_q == XW'(COLS - 1);
        row_take   = close && cnt_inc > CW'(MIN_COUNT) && cnt_inc > rb_cnt_q;
        rb_cnt_n   = row_take ? cnt_inc : rb_cnt_q;
        rb_col_n   = row_take ? s1_col_q : rb_col_q;
        frame_take = row_end && rb_cnt_n > fb_cnt_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < COLS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < COLS; i++) if (clr) cnt_q[i] <= '0;
            if (acc_en) cnt_q[s1_col_q] <= close ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rb_cnt_q <= '0;
            rb_col_q <= '0;
            fb_cnt_q <= '0;
            fb_col_q <= '0;
            fb_row_q <= '0;
        end else begin
            if (clr || row_end) begin
                rb_cnt_q <= '0;
                rb_col_q <= '0;
            end else if (row_take) begin
                rb_cnt_q <= cnt_inc;
                rb_col_q <= s1_col_q;
            end
            if (clr) begin
                fb_cnt_q <= '0;
                fb_col_q <= '0;
                fb_row_q <= '0;
            end else if (frame_take) begin
                fb_cnt_q <= rb_cnt_n;
                fb_col_q <= rb_col_n;
                fb_row_q <= s1_row_q;
            end
        end
    end

    logic [XW-1:0] ball_x_q;
    logic [YW-1:0] ball_y_q;
    logic [CW-1:0] ball_cnt_q;
    logic          ball_found_q, ball_valid_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ball_x_q     <= '0;
            ball_y_q     <= '0;
            ball_cnt_q   <= '0;
            ball_found_q <= 1'b0;
            ball_valid_q <= 1'b0;
        end else begin
            ball_valid_q <= publish;
            if (publish) begin
                ball_x_q     <= fb_col_q;
                ball_y_q     <= fb_row_q;
                ball_cnt_q   <= fb_cnt_q;
                ball_found_q <= fb_cnt_q != '0;
            end
        end
    end

    assign BALL_X     = ball_x_q;
    assign BALL_Y     = ball_y_q;
    assign BALL_COUNT = ball_cnt_q;
    assign BALL_FOUND = ball_found_q;
    assign BALL_VALID = ball_valid_q;

    // A cell holds at most BLOCK*BLOCK hits, which CW bits always represent.
    assert property (@(posedge CLK) disable iff (!RESET_N) !(acc_en && cnt_base == CNT_MAX));

    logic [7:0] vid_r, vid_g, vid_b;
`ifdef OVERLAY_EN
    logic s1_mark_q, paint_ball, paint_hit;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       s1_mark_q <= 1'b0;
        else if (PIX_VALID) s1_mark_q <= ENABLE_MARK;
    end
    always_comb begin
        paint_ball = s1_act_q && ball_found_q && s1_col_q == ball_x_q && s1_row_q == ball_y_q;
        paint_hit  = s1_mark_q && s1_hit_q;
        vid_r      = paint_ball ? 8'hff : paint_hit ? 8'h00 : s1_r_q;
        vid_g      = paint_ball ? 8'h00 : paint_hit ? 8'hff : s1_g_q;
        vid_b      = (paint_ball || paint_hit) ? 8'h00 : s1_b_q;
    end
`else
    logic unused_mark;
    assign unused_mark = ENABLE_MARK;
    always_comb begin
        vid_r = s1_r_q;
        vid_g = s1_g_q;
        vid_b = s1_b_q;
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            R_OUT <= '0;
            G_OUT <= '0;
            B_OUT <= '0;
        end else if (PIX_VALID) begin
            R_OUT <= vid_r;
            G_OUT <= vid_g;
            B_OUT <= vid_b;
        end
    end
endmodule

// File: tb/tb_ball_grid_tracker.sv
// tb_ball_grid_tracker: directed frames with a publish scoreboard for ball_grid_tracker
//
// Frames are driven sparsely: only hit pixels and the closing pixel of every
// cell (last line, last column of the cell) are presented, which is all the
// tracker needs to close cells, end rows and reach the last active pixel.
module tb_ball_grid_tracker;
    localparam int XW = 6, YW = 5, CW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, pv, mark;
    logic [12:0]   h, v;
    logic [7:0]    r, g, b, ro, go, bo;
    logic [XW-1:0] bx;
    logic [YW-1:0] by;
    logic [CW-1:0] bc;
    logic          found, valid;

    ball_grid_tracker dut (
        .CLK(clk), .RESET_N(rst_n), .PIX_VALID(pv),
        .VGA_H_CNT(h), .VGA_V_CNT(v),
        .R_IN(r), .G_IN(g), .B_IN(b), .ENABLE_MARK(mark),
        .R_OUT(ro), .G_OUT(go), .B_OUT(bo),
        .BALL_X(bx), .BALL_Y(by), .BALL_COUNT(bc),
        .BALL_FOUND(found), .BALL_VALID(valid)
    );

    typedef struct {bit f; int x; int y; int c;} exp_t;
    typedef struct {int c; int r; int n;} cell_t;

    exp_t  exp_q[$];
    exp_t  last_e;
    cell_t cells[$];
    int    n_asserts = 0;
    int    n_fail = 0;
    bit    stall_en = 1'b0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every BALL_VALID pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            chk("unexpected_valid", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                last_e = exp_q.pop_front();
                chk("ball_found", int'(found), int'(last_e.f));
                chk("ball_x", int'(bx), last_e.x);
                chk("ball_y", int'(by), last_e.y);
                chk("ball_count", int'(bc), last_e.c);
            end
        end
    end

    task automatic expect_pub(input bit f, input int x, input int y, input int c);
        exp_t e;
        e.f = f; e.x = x; e.y = y; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int hh, input int vv, input int gg, input bit p);
        @(negedge clk);
        h = 13'(hh); v = 13'(vv); r = 8'd0; g = 8'(gg); b = 8'd0; pv = p;
    endtask

    task automatic send(input int x, input int y, input bit hitp);
        if (stall_en && $urandom_range(0, 1) == 1)
            drive($urandom_range(0, 900), $urandom_range(0, 600), 200, 1'b0);
        drive(x + 144, y + 35, hitp ? 200 : 0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, $urandom_range(0, 255), 1'b1);
    endtask

    function automatic int hits(input int c, input int rr);
        foreach (cells[i]) if (cells[i].c == c && cells[i].r == rr) return cells[i].n;
        return 0;
    endfunction

    task automatic frame(input bit start, input int r0, input int r1, input bit pub);
        if (start) send(0, 0, 1'b0);
        for (int rr = r0; rr <= r1; rr++) begin
            foreach (cells[i])
                if (cells[i].r == rr)
                    for (int k = 0; k < cells[i].n - 1; k++)
                        send(cells[i].c * 16 + k % 16, rr * 16 + k / 16, 1'b1);
            for (int c = 0; c < 40; c++) send(c * 16 + 15, rr * 16 + 15, hits(c, rr) > 0);
        end
        if (pub) begin
            if (!stall_en) begin
                idle(1); chk("latency_edge1", int'(valid), 0);
                idle(1); chk("latency_edge2", int'(valid), 0);
                idle(1); chk("latency_edge3", int'(valid), 1);
            end
            idle(6);
            chk("publish_seen", exp_q.size(), 0);
            chk("hold_x", int'(bx), last_e.x);
            chk("hold_y", int'(by), last_e.y);
            chk("hold_count", int'(bc), last_e.c);
        end
    endtask

    initial begin
        rst_n = 1'b0; pv = 1'b0; mark = 1'b0;
        h = '0; v = '0; r = '0; g = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_x", int'(bx), 0);
        chk("rst_y", int'(by), 0);
        chk("rst_count", int'(bc), 0);
        chk("rst_r", int'(ro), 0);
        chk("rst_g", int'(go), 0);
        chk("rst_b", int'(bo), 0);
        rst_n = 1'b1;

        // Video delay and stall hold (plain build: output equals input).
        @(negedge clk); h = 13'd0; v = 13'd0; r = 8'h12; g = 8'h34; b = 8'h56; pv = 1'b1; mark = 1'b1;
        @(negedge clk); r = 8'h9a; g = 8'hbc; b = 8'hde;
        @(negedge clk);
        chk("video_r", int'(ro), 'h12);
        chk("video_g", int'(go), 'h34);
        chk("video_b", int'(bo), 'h56);
        pv = 1'b0; r = 8'h01; g = 8'h02; b = 8'h03;
        @(negedge clk);
        chk("video_stall_hold", int'(ro), 'h12);
        pv = 1'b1;
        @(negedge clk);
        chk("video_next_r", int'(ro), 'h9a);
        mark = 1'b0;

        cells.delete();
        expect_pub(1'b0, 0, 0, 0);
        frame(1'b1, 0, 29, 1'b1);

        cells = '{'{5, 7, 256}};
        expect_pub(1'b1, 5, 7, 256);
        frame(1'b1, 0, 29, 1'b1);

        cells = '{'{3, 2, 200}, '{9, 2, 200}, '{1, 10, 150}};
        expect_pub(1'b1, 3, 2, 200);
        frame(1'b1, 0, 29, 1'b1);

        cells = '{'{4, 4, 128}};
        expect_pub(1'b0, 0, 0, 0);
        frame(1'b1, 0, 29, 1'b1);

        cells = '{'{4, 4, 129}};
        expect_pub(1'b1, 4, 4, 129);
        frame(1'b1, 0, 29, 1'b1);

        // Abandoned partial frame with a larger ball, then (0,0) restarts accumulation.
        cells = '{'{2, 1, 250}};
        frame(1'b1, 0, 12, 1'b0);
        cells = '{'{20, 25, 200}};
        expect_pub(1'b1, 20, 25, 200);
        frame(1'b1, 0, 29, 1'b1);

        stall_en = 1'b1;
        cells = '{'{5, 7, 256}};
        expect_pub(1'b1, 5, 7, 256);
        frame(1'b1, 0, 29, 1'b1);
        stall_en = 1'b0;

        // Reset partway through a frame; the tail of that frame must not publish.
        frame(1'b1, 0, 10, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_found", int'(found), 0);
        chk("midrst_x", int'(bx), 0);
        chk("midrst_y", int'(by), 0);
        chk("midrst_count", int'(bc), 0);
        @(negedge clk) rst_n = 1'b1;
        frame(1'b0, 11, 29, 1'b0);
        idle(6);
        chk("no_publish_after_reset", int'(found), 0);
        cells = '{'{20, 25, 200}};
        expect_pub(1'b1, 20, 25, 200);
        frame(1'b1, 0, 29, 1'b1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
